// File: rtl/digital_clock_pkg.sv
// Shared types and BCD hour limits for the digital clock hour stage.
package digital_clock_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD      = 2'd1,
      ACK       = 2'd2,
      WAIT_DROP = 2'd3
   } state_t;

   localparam logic [7:0] HR12_MIN = 8'h01;
   localparam logic [7:0] HR12_MAX = 8'h12;
   localparam logic [7:0] HR24_MAX = 8'h23;

endpackage

// File: rtl/hour_counter_bcd_next.sv
// hour_bcd_next: combinational BCD hour increment with 11->12 wrap flag.
// Build option HOUR24_EN selects the 00..23 sequence (wrap flag held low).
module hour_bcd_next
   import digital_clock_pkg::*;
(
   input  logic [7:0] hr,
   output logic [7:0] hr_next,
   output logic       wrap_11_12
);

`ifdef HOUR24_EN
   localparam logic [7:0] TOP_HR   = HR24_MAX;
   localparam logic [7:0] FIRST_HR = 8'h00;
   localparam bit         AMPM_EN  = 1'b0;
`else
   localparam logic [7:0] TOP_HR   = HR12_MAX;
   localparam logic [7:0] FIRST_HR = HR12_MIN;
   localparam bit         AMPM_EN  = 1'b1;
`endif

   always_comb begin
      hr_next    = hr;
      wrap_11_12 = AMPM_EN && (hr == 8'h11);
      if (hr >= TOP_HR)
         hr_next = FIRST_HR;
      else if (hr[3:0] >= 4'd9)
         hr_next = {hr[7:4] + 4'd1, 4'd0};
      else
         hr_next = {hr[7:4], hr[3:0] + 4'd1};
   end

endmodule

// File: rtl/hour_counter_bcd.sv
// BCD hour counter with set handshake and AM/PM toggle pulse.
// Build option HOUR24_EN selects 24-hour mode (ampm_tgl never pulses).
//
// state     | meaning
// IDLE      | counting; hr_tick advances hour, set_req starts a load
// LOAD      | write set_val if valid, raise set_ack/set_err next cycle
// ACK       | set_ack (and set_err if rejected) high for this cycle
// WAIT_DROP | handshake done, wait for set_req to fall
module hour_counter_bcd
   import digital_clock_pkg::*;
#(
   parameter logic [7:0] RST_HOUR = 8'h12
)
(
   input  logic       clk1,
   input  logic       clr,
   input  logic       hr_tick,
   input  logic       set_req,
   input  logic [7:0] set_val,
   output logic       set_ack,
   output logic       set_err,
   output logic [7:0] hr_bcd,
   output logic       ampm_tgl
);

   state_t     state;
   logic [7:0] hr_next;
   logic       wrap_11_12;
   logic       set_valid;

   hour_bcd_next u_next (
      .hr         (hr_bcd),
      .hr_next    (hr_next),
      .wrap_11_12 (wrap_11_12)
   );

   // Nibble check first, then range; packed BCD compares correctly once nibbles are decimal.
   always_comb begin
      set_valid = 1'b1;
      if (set_val[7:4] > 4'd9 || set_val[3:0] > 4'd9)
         set_valid = 1'b0;
`ifdef HOUR24_EN
      else if (set_val > HR24_MAX)
         set_valid = 1'b0;
`else
      else if (set_val < HR12_MIN || set_val > HR12_MAX)
         set_valid = 1'b0;
`endif
   end

   always_ff @(posedge clk1 or posedge clr) begin
      if (clr) begin
         state    <= IDLE;
         hr_bcd   <= RST_HOUR;
         set_ack  <= 1'b0;
         set_err  <= 1'b0;
         ampm_tgl <= 1'b0;
      end else begin
         set_ack  <= 1'b0;
         set_err  <= 1'b0;
         ampm_tgl <= 1'b0;
         case (state)
            IDLE: begin
               // A load request outranks a tick arriving in the same cycle.
               if (set_req)
                  state <= LOAD;
               else if (hr_tick) begin
                  hr_bcd   <= hr_next;
                  ampm_tgl <= wrap_11_12;
               end
            end
            LOAD: begin
               if (set_valid)
                  hr_bcd <= set_val;
               set_ack <= 1'b1;
               set_err <= ~set_valid;
               state   <= ACK;
            end
            ACK:
               state <= WAIT_DROP;
            WAIT_DROP:
               if (!set_req)
                  state <= IDLE;
            default:
               state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hour_counter_bcd.sv
// Scoreboard bench for hour_counter_bcd; follows HOUR24_EN like the design.
module tb_hour_counter_bcd;

`ifdef HOUR24_EN
   localparam bit H24 = 1'b1;
`else
   localparam bit H24 = 1'b0;
`endif

   localparam logic [7:0] RST_HR   = 8'h12;
   localparam logic [7:0] BAD_HOUR = H24 ? 8'h24 : 8'h13;

   localparam logic [1:0] EV_HR   = 2'd0;
   localparam logic [1:0] EV_AMPM = 2'd1;
   localparam logic [1:0] EV_ACK  = 2'd2;

   typedef struct {
      logic [1:0] kind;
      logic [7:0] val;
   } ev_t;

   logic       clk1 = 1'b0;
   logic       clr;
   logic       hr_tick;
   logic       set_req;
   logic [7:0] set_val;
   logic       set_ack;
   logic       set_err;
   logic [7:0] hr_bcd;
   logic       ampm_tgl;

   ev_t        exp_q[$];
   int         n_pass  = 0;
   int         n_total = 0;
   logic [7:0] cur_hr;

   hour_counter_bcd #(.RST_HOUR(RST_HR)) dut (
      .clk1     (clk1),
      .clr      (clr),
      .hr_tick  (hr_tick),
      .set_req  (set_req),
      .set_val  (set_val),
      .set_ack  (set_ack),
      .set_err  (set_err),
      .hr_bcd   (hr_bcd),
      .ampm_tgl (ampm_tgl)
   );

   always #5 clk1 = ~clk1;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic push(input logic [1:0] kind, input logic [7:0] val);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   task automatic pop_check(input string name, input logic [1:0] kind, input logic [7:0] val);
      ev_t e;
      if (exp_q.size() == 0)
         chk({"unexpected_", name}, {6'd0, kind, val}, 16'hFFFF);
      else begin
         e = exp_q.pop_front();
         chk(name, {6'd0, kind, val}, {6'd0, e.kind, e.val});
      end
   endtask

   // Monitor: every hour change, ampm pulse and ack pulse must match the queue in order.
   initial begin
      logic [7:0] prev;
      prev = RST_HR;
      forever begin
         @(negedge clk1);
         if (clr) begin
            prev = hr_bcd;
         end else begin
            if (hr_bcd !== prev) begin
               pop_check("hr_change", EV_HR, hr_bcd);
               prev = hr_bcd;
            end
            if (ampm_tgl !== 1'b0)
               pop_check("ampm_pulse", EV_AMPM, 8'h00);
            if (set_ack !== 1'b0)
               pop_check("ack_pulse", EV_ACK, {7'd0, set_err});
            else if (set_err !== 1'b0)
               chk("err_without_ack", {15'd0, set_err}, 16'd0);
         end
      end
   end

   // All tasks below start and end 1 time unit after a rising edge.
   task automatic tick(input logic [7:0] exp_hr, input bit exp_ampm);
      push(EV_HR, exp_hr);
      if (exp_ampm)
         push(EV_AMPM, 8'h00);
      cur_hr  = exp_hr;
      hr_tick = 1'b1;
      @(posedge clk1); #1;
      hr_tick = 1'b0;
      @(posedge clk1); #1;
   endtask

   task automatic do_set(input logic [7:0] val, input bit valid);
      if (valid && val != cur_hr)
         push(EV_HR, val);
      if (valid)
         cur_hr = val;
      push(EV_ACK, {7'd0, ~valid});
      set_val = val;
      set_req = 1'b1;
      @(posedge clk1); #1;
      chk("ack_not_early", {15'd0, set_ack}, 16'd0);
      @(posedge clk1); #1;
      chk("ack_latency", {15'd0, set_ack}, 16'd1);
      // Ticks during ACK/WAIT_DROP must be dropped.
      hr_tick = 1'b1;
      repeat (3) @(posedge clk1);
      #1;
      hr_tick = 1'b0;
      set_req = 1'b0;
      @(posedge clk1); #1;
      @(posedge clk1); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] t12 [10];
      t12 = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h10, 8'h11};

      clr     = 1'b1;
      hr_tick = 1'b0;
      set_req = 1'b0;
      set_val = 8'h00;
      cur_hr  = RST_HR;
      repeat (3) @(posedge clk1);
      #1;
      chk("rst_hr", {8'd0, hr_bcd}, {8'd0, RST_HR});
      chk("rst_ack", {15'd0, set_ack}, 16'd0);
      chk("rst_err", {15'd0, set_err}, 16'd0);
      chk("rst_ampm", {15'd0, ampm_tgl}, 16'd0);

      // Tick honoured on the first edge after clr release.
      push(EV_HR, H24 ? 8'h13 : 8'h01);
      cur_hr  = H24 ? 8'h13 : 8'h01;
      clr     = 1'b0;
      hr_tick = 1'b1;
      @(posedge clk1); #1;
      hr_tick = 1'b0;
      @(posedge clk1); #1;

      if (H24) begin
         do_set(8'h23, 1'b1);
         tick(8'h00, 1'b0);
         do_set(8'h19, 1'b1);
         tick(8'h20, 1'b0);
      end else begin
         for (int i = 0; i < 10; i++)
            tick(t12[i], 1'b0);
         tick(8'h12, 1'b1);
         tick(8'h01, 1'b0);
      end

      do_set(8'h07, 1'b1);
      do_set(BAD_HOUR, 1'b0);
      do_set(8'h1A, 1'b0);
      do_set(8'hA1, 1'b0);
      do_set(8'h05, 1'b1);

      // Tick and set_req together in IDLE: the load wins, no 06 ever appears.
      push(EV_HR, 8'h09);
      push(EV_ACK, 8'h00);
      cur_hr  = 8'h09;
      set_val = 8'h09;
      set_req = 1'b1;
      hr_tick = 1'b1;
      @(posedge clk1); #1;
      hr_tick = 1'b0;
      repeat (3) @(posedge clk1);
      #1;
      set_req = 1'b0;
      repeat (2) @(posedge clk1);
      #1;

      // clr in LOAD aborts; set_req still high restarts the handshake.
      set_val = 8'h03;
      set_req = 1'b1;
      @(posedge clk1); #1;
      clr = 1'b1;
      #1;
      chk("clr_load_hr", {8'd0, hr_bcd}, {8'd0, RST_HR});
      chk("clr_load_ack", {15'd0, set_ack}, 16'd0);
      cur_hr = RST_HR;
      push(EV_HR, 8'h03);
      push(EV_ACK, 8'h00);
      cur_hr = 8'h03;
      @(posedge clk1); #1;
      clr = 1'b0;
      repeat (4) @(posedge clk1);
      #1;
      set_req = 1'b0;
      repeat (2) @(posedge clk1);
      #1;

      // clr while set_ack is high drops it immediately.
      set_val = 8'h04;
      set_req = 1'b1;
      repeat (2) @(posedge clk1);
      #1;
      chk("pre_clr_ack", {15'd0, set_ack}, 16'd1);
      clr = 1'b1;
      #1;
      chk("clr_ack_ack", {15'd0, set_ack}, 16'd0);
      chk("clr_ack_hr", {8'd0, hr_bcd}, {8'd0, RST_HR});
      set_req = 1'b0;
      cur_hr  = RST_HR;
      @(posedge clk1); #1;
      clr = 1'b0;
      @(posedge clk1); #1;

      tick(H24 ? 8'h13 : 8'h01, 1'b0);

      repeat (5) @(posedge clk1);
      for (int i = 0; i < 20 && exp_q.size() != 0; i++)
         @(posedge clk1);
      chk("queue_drained", exp_q.size(), 16'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
